instr_fetch: RTL and testbench

- Initiator side of the instruction-memory req/gnt/rvalid interface; the instr_ram block is the responder.
- Generates sequential fetch addresses from a boot address and holds requests until granted.
- Captures returned instructions with their PC into a small FIFO and presents them to the decode stage with valid/ready.
- Handles redirects (branch/jump) and flags a fetch error when the memory never grants.

---
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential req/gnt/rvalid fetches into a small PC+instruction FIFO toward decode.
// Handles redirects, drops responses that belong to flushed transactions, and flags a sticky error when memory stalls.
module instr_fetch #(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
   parameter logic [31:0] ADDR_STEP  = 32'd1,
   parameter int          FIFO_DEPTH = 4,
   parameter int          TIMEOUT    = 16
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   output logic                         instr_req_o,
   output logic [31:0]                  instr_addr_o,
   input  logic                         instr_gnt_in,
   input  logic                         instr_rvalid_in,
   input  logic [31:0]                  instr_rdata_in,
   output logic                         fetch_valid_o,
   input  logic                         fetch_ready_in,
   output logic [31:0]                  fetch_instr_o,
   output logic [31:0]                  fetch_pc_o,
   input  logic                         redirect_in,
   input  logic [31:0]                  redirect_addr_in,
   output logic                         fetch_err_o,
   output logic [1:0]                   dbg_state_o,
   output logic [$clog2(FIFO_DEPTH):0]  dbg_count_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_t;

   state_t        r_state;
   logic [31:0]   r_addr;
   logic [31:0]   r_pc;
   logic [31:0]   r_tmo;
   logic          r_pend;
   logic          r_discard;
   logic [31:0]   r_mem_instr [FIFO_DEPTH];
   logic [31:0]   r_mem_pc    [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_gnt;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_push_pc;

   // Handshake: a request is accepted on a cycle with instr_req_o & instr_gnt_in; its data arrives on
   // that cycle or a later one flagged by instr_rvalid_in. Decode consumes the head when fetch_valid_o & fetch_ready_in.
   // Nothing is outstanding in S_REQ, so the FIFO space check needs only the count there.
   assign instr_req_o   = !rst_in && (r_state == S_REQ) && (r_count != DEPTH_C);
   assign instr_addr_o  = r_addr;
   assign fetch_valid_o = (r_count != '0);
   assign fetch_instr_o = r_mem_instr[r_rptr];
   assign fetch_pc_o    = r_mem_pc[r_rptr];
   assign fetch_err_o   = (r_state == S_ERR);
   assign dbg_state_o   = r_state;
   assign dbg_count_o   = r_count;

   assign w_gnt = instr_req_o && instr_gnt_in;
   assign w_pop = fetch_valid_o && fetch_ready_in && !redirect_in;

   always_comb begin
      w_push    = 1'b0;
      w_push_pc = r_addr;
      if (!redirect_in) begin
         if (r_state == S_REQ && w_gnt && instr_rvalid_in) begin
            w_push = 1'b1;
         end else if (r_state == S_WAIT && instr_rvalid_in && !r_discard) begin
            w_push    = 1'b1;
            w_push_pc = r_pc;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state   <= S_REQ;
         r_addr    <= BOOT_ADDR;
         r_pc      <= BOOT_ADDR;
         r_tmo     <= '0;
         r_pend    <= 1'b0;
         r_discard <= 1'b0;
      end else if (redirect_in) begin
         r_addr <= redirect_addr_in;
         r_tmo  <= '0;
         // A transaction still in flight must drain before the new stream may issue.
         if ((r_pend || w_gnt) && !instr_rvalid_in) begin
            r_state   <= S_WAIT;
            r_pend    <= 1'b1;
            r_discard <= 1'b1;
         end else begin
            r_state   <= S_REQ;
            r_pend    <= 1'b0;
            r_discard <= 1'b0;
         end
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_gnt) begin
                  r_addr <= r_addr + ADDR_STEP;
                  r_tmo  <= '0;
                  if (!instr_rvalid_in) begin
                     r_state <= S_WAIT;
                     r_pc    <= r_addr;
                     r_pend  <= 1'b1;
                  end
               end else if (instr_req_o) begin
                  r_tmo <= r_tmo + 32'd1;
                  if (r_tmo == TMO_LAST) r_state <= S_ERR;
               end
            end
            S_WAIT: begin
               if (instr_rvalid_in) begin
                  r_state   <= S_REQ;
                  r_pend    <= 1'b0;
                  r_discard <= 1'b0;
                  r_tmo     <= '0;
               end else begin
                  r_tmo <= r_tmo + 32'd1;
                  if (r_tmo == TMO_LAST) r_state <= S_ERR;
               end
            end
            S_ERR: begin
               if (instr_rvalid_in) begin
                  r_pend    <= 1'b0;
                  r_discard <= 1'b0;
                  r_tmo     <= '0;
               end
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || redirect_in) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem_instr[r_wptr] <= instr_rdata_in;
            r_mem_pc[r_wptr]    <= w_push_pc;
            r_wptr              <= r_wptr + PW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && !redirect_in) assert (!(w_push && r_count == DEPTH_C));
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of streaming cycles plus hand-written sequences for
// delayed response, redirect with a stale response, timeout error, address wrap and mid-transaction reset.
module tb_instr_fetch;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_in;
   logic        instr_rvalid_in;
   logic [31:0] instr_rdata_in;
   logic        fetch_valid_o;
   logic        fetch_ready_in = 1'b0;
   logic [31:0] fetch_instr_o;
   logic [31:0] fetch_pc_o;
   logic        redirect_in = 1'b0;
   logic [31:0] redirect_addr_in = 32'h0;
   logic        fetch_err_o;
   logic [1:0]  dbg_state_o;
   logic [2:0]  dbg_count_o;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic        gnt_en   = 1'b1;
   logic        withhold = 1'b0;
   int          delay    = 0;
   int          dly_cnt  = 0;
   logic [31:0] dly_addr = 32'h0;

   instr_fetch dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .instr_req_o      (instr_req_o),
      .instr_addr_o     (instr_addr_o),
      .instr_gnt_in     (instr_gnt_in),
      .instr_rvalid_in  (instr_rvalid_in),
      .instr_rdata_in   (instr_rdata_in),
      .fetch_valid_o    (fetch_valid_o),
      .fetch_ready_in   (fetch_ready_in),
      .fetch_instr_o    (fetch_instr_o),
      .fetch_pc_o       (fetch_pc_o),
      .redirect_in      (redirect_in),
      .redirect_addr_in (redirect_addr_in),
      .fetch_err_o      (fetch_err_o),
      .dbg_state_o      (dbg_state_o),
      .dbg_count_o      (dbg_count_o)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] img(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
   endfunction

   // Memory model: grants when enabled (never at 0x0001_0000 when withholding); responds same cycle
   // when delay is 0, otherwise 'delay' cycles after the grant.
   always_comb begin
      instr_gnt_in    = instr_req_o && gnt_en && !(withhold && instr_addr_o == 32'h0001_0000);
      instr_rvalid_in = 1'b0;
      instr_rdata_in  = 32'h0;
      if (dly_cnt == 1) begin
         instr_rvalid_in = 1'b1;
         instr_rdata_in  = img(dly_addr);
      end else if (delay == 0 && instr_gnt_in) begin
         instr_rvalid_in = 1'b1;
         instr_rdata_in  = img(instr_addr_o);
      end
   end

   always @(posedge clk_in) begin
      if (instr_req_o && instr_gnt_in && delay != 0) begin
         dly_cnt  <= delay;
         dly_addr <= instr_addr_o;
      end else if (dly_cnt != 0) begin
         dly_cnt <= dly_cnt - 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_in);
      #2;
   endtask

   // Returns in the first cycle with rst_in low, outputs settled.
   task automatic do_reset();
      rst_in = 1'b1;
      repeat (2) next_cycle();
      #1;
      chk("rst req", {31'h0, instr_req_o}, 32'h0);
      chk("rst addr", instr_addr_o, 32'h0);
      chk("rst valid", {31'h0, fetch_valid_o}, 32'h0);
      chk("rst err", {31'h0, fetch_err_o}, 32'h0);
      chk("rst count", {29'h0, dbg_count_o}, 32'h0);
      chk("rst state", {30'h0, dbg_state_o}, 32'h0);
      rst_in = 1'b0;
      #1;
   endtask

   typedef struct {
      logic        ready;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [2:0]  exp_cnt;
   } vec_t;

   vec_t vt[19];
   int   req_cycles;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0, 3'd0};
      vt[1]  = '{1'b1, 1'b1, 32'd1,  1'b1, 32'd0, 3'd1};
      vt[2]  = '{1'b1, 1'b1, 32'd2,  1'b1, 32'd1, 3'd1};
      vt[3]  = '{1'b1, 1'b1, 32'd3,  1'b1, 32'd2, 3'd1};
      vt[4]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd3, 3'd1};
      vt[5]  = '{1'b0, 1'b1, 32'd5,  1'b1, 32'd3, 3'd2};
      vt[6]  = '{1'b0, 1'b1, 32'd6,  1'b1, 32'd3, 3'd3};
      for (int i = 7; i < 14; i++) vt[i] = '{1'b0, 1'b0, 32'd7, 1'b1, 32'd3, 3'd4};
      vt[14] = '{1'b1, 1'b0, 32'd7,  1'b1, 32'd3, 3'd4};
      vt[15] = '{1'b1, 1'b1, 32'd7,  1'b1, 32'd4, 3'd3};
      vt[16] = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd5, 3'd3};
      vt[17] = '{1'b1, 1'b1, 32'd9,  1'b1, 32'd6, 3'd3};
      vt[18] = '{1'b1, 1'b1, 32'd10, 1'b1, 32'd7, 3'd3};

      // Streaming, back-pressure fill and drain
      delay = 0; gnt_en = 1'b1; withhold = 1'b0;
      do_reset();
      for (int i = 0; i < 19; i++) begin
         if (i > 0) next_cycle();
         fetch_ready_in = vt[i].ready;
         #1;
         chk($sformatf("vec%0d req", i), {31'h0, instr_req_o}, {31'h0, vt[i].exp_req});
         chk($sformatf("vec%0d addr", i), instr_addr_o, vt[i].exp_addr);
         chk($sformatf("vec%0d valid", i), {31'h0, fetch_valid_o}, {31'h0, vt[i].exp_valid});
         chk($sformatf("vec%0d count", i), {29'h0, dbg_count_o}, {29'h0, vt[i].exp_cnt});
         if (vt[i].exp_valid) begin
            chk($sformatf("vec%0d pc", i), fetch_pc_o, vt[i].exp_pc);
            chk($sformatf("vec%0d instr", i), fetch_instr_o, img(vt[i].exp_pc));
         end
      end

      // rvalid three cycles after gnt
      delay = 3; fetch_ready_in = 1'b1;
      do_reset();
      chk("dly c0 req", {31'h0, instr_req_o}, 32'h1);
      next_cycle(); #1;
      chk("dly c1 req", {31'h0, instr_req_o}, 32'h0);
      chk("dly c1 state", {30'h0, dbg_state_o}, 32'h1);
      next_cycle(); #1;
      chk("dly c2 req", {31'h0, instr_req_o}, 32'h0);
      next_cycle(); #1;
      chk("dly c3 req", {31'h0, instr_req_o}, 32'h0);
      chk("dly c3 valid", {31'h0, fetch_valid_o}, 32'h0);
      next_cycle(); delay = 0; #1;
      chk("dly c4 valid", {31'h0, fetch_valid_o}, 32'h1);
      chk("dly c4 pc", fetch_pc_o, 32'h0);
      chk("dly c4 instr", fetch_instr_o, img(32'h0));
      chk("dly c4 addr", instr_addr_o, 32'h1);
      chk("dly c4 req", {31'h0, instr_req_o}, 32'h1);

      // Redirect with two buffered entries, an outstanding fetch and a coincident pop
      delay = 0; fetch_ready_in = 1'b0;
      do_reset();
      next_cycle();
      next_cycle(); delay = 5; #1;
      chk("redir c2 count", {29'h0, dbg_count_o}, 32'h2);
      chk("redir c2 addr", instr_addr_o, 32'h2);
      next_cycle(); fetch_ready_in = 1'b1; redirect_in = 1'b1; redirect_addr_in = 32'h40; #1;
      chk("redir c3 req", {31'h0, instr_req_o}, 32'h0);
      chk("redir c3 count", {29'h0, dbg_count_o}, 32'h2);
      next_cycle(); redirect_in = 1'b0; delay = 0; #1;
      chk("redir c4 valid", {31'h0, fetch_valid_o}, 32'h0);
      chk("redir c4 count", {29'h0, dbg_count_o}, 32'h0);
      chk("redir c4 req", {31'h0, instr_req_o}, 32'h0);
      chk("redir c4 addr", instr_addr_o, 32'h40);
      next_cycle(); #1;
      chk("redir c5 req", {31'h0, instr_req_o}, 32'h0);
      next_cycle();
      next_cycle(); #1;
      chk("redir c7 req", {31'h0, instr_req_o}, 32'h0);
      chk("redir c7 valid", {31'h0, fetch_valid_o}, 32'h0);
      next_cycle(); #1;
      chk("redir c8 req", {31'h0, instr_req_o}, 32'h1);
      chk("redir c8 addr", instr_addr_o, 32'h40);
      chk("redir c8 valid", {31'h0, fetch_valid_o}, 32'h0);
      next_cycle(); #1;
      chk("redir c9 valid", {31'h0, fetch_valid_o}, 32'h1);
      chk("redir c9 pc", fetch_pc_o, 32'h40);
      chk("redir c9 instr", fetch_instr_o, img(32'h40));

      // Grant withheld at 0x0001_0000: timeout, drain in error, recovery by redirect
      delay = 0; withhold = 1'b1; fetch_ready_in = 1'b0;
      redirect_in = 1'b1; redirect_addr_in = 32'h0000_FFFE;
      do_reset();
      next_cycle(); redirect_in = 1'b0; #1;
      chk("tmo c1 addr", instr_addr_o, 32'h0000_FFFE);
      next_cycle();
      next_cycle(); #1;
      chk("tmo c3 addr", instr_addr_o, 32'h0001_0000);
      chk("tmo c3 req", {31'h0, instr_req_o}, 32'h1);
      chk("tmo c3 count", {29'h0, dbg_count_o}, 32'h2);
      req_cycles = 1;
      for (int k = 0; k < 30 && instr_req_o; k++) begin
         next_cycle(); #1;
         if (instr_req_o) req_cycles++;
      end
      chk("tmo req cycles", req_cycles, 32'd16);
      chk("tmo err", {31'h0, fetch_err_o}, 32'h1);
      chk("tmo req low", {31'h0, instr_req_o}, 32'h0);
      chk("tmo state", {30'h0, dbg_state_o}, 32'h2);
      chk("tmo drain0 pc", fetch_pc_o, 32'h0000_FFFE);
      fetch_ready_in = 1'b1;
      next_cycle(); #1;
      chk("tmo drain1 pc", fetch_pc_o, 32'h0000_FFFF);
      chk("tmo drain1 instr", fetch_instr_o, img(32'h0000_FFFF));
      chk("tmo drain1 err", {31'h0, fetch_err_o}, 32'h1);
      next_cycle(); #1;
      chk("tmo empty valid", {31'h0, fetch_valid_o}, 32'h0);
      redirect_in = 1'b1; redirect_addr_in = 32'h0; withhold = 1'b0;
      next_cycle(); redirect_in = 1'b0; #1;
      chk("tmo clr err", {31'h0, fetch_err_o}, 32'h0);
      chk("tmo clr req", {31'h0, instr_req_o}, 32'h1);
      chk("tmo clr addr", instr_addr_o, 32'h0);
      next_cycle(); #1;
      chk("tmo resume pc", fetch_pc_o, 32'h0);
      chk("tmo resume valid", {31'h0, fetch_valid_o}, 32'h1);

      // Address wrap at 2^32
      redirect_in = 1'b1; redirect_addr_in = 32'hFFFF_FFFF; fetch_ready_in = 1'b1;
      do_reset();
      next_cycle(); redirect_in = 1'b0; #1;
      chk("wrap c1 addr", instr_addr_o, 32'hFFFF_FFFF);
      next_cycle(); #1;
      chk("wrap c2 addr", instr_addr_o, 32'h0);
      chk("wrap c2 pc", fetch_pc_o, 32'hFFFF_FFFF);
      chk("wrap c2 instr", fetch_instr_o, img(32'hFFFF_FFFF));
      next_cycle(); #1;
      chk("wrap c3 pc", fetch_pc_o, 32'h0);

      // Reset in the middle of an outstanding fetch; its late rvalid must be ignored
      delay = 3; fetch_ready_in = 1'b1;
      do_reset();
      next_cycle(); rst_in = 1'b1; gnt_en = 1'b0;
      next_cycle(); rst_in = 1'b0;
      next_cycle(); #1;
      chk("rstmid c3 rvalid seen", {31'h0, instr_rvalid_in}, 32'h1);
      next_cycle(); gnt_en = 1'b1; delay = 0; #1;
      chk("rstmid c4 valid", {31'h0, fetch_valid_o}, 32'h0);
      chk("rstmid c4 count", {29'h0, dbg_count_o}, 32'h0);
      chk("rstmid c4 addr", instr_addr_o, 32'h0);
      next_cycle(); #1;
      chk("rstmid c5 pc", fetch_pc_o, 32'h0);
      chk("rstmid c5 instr", fetch_instr_o, img(32'h0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
